// File: rtl/matrix_dma_pkg.sv
// Shared definitions for the pixel-buffer <-> SDRAM DMA engines (loader and capture).
package matrix_dma_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } dma_state_e;

    localparam int unsigned PIX_W    = 12;
    localparam int unsigned LANES    = 4;
    localparam int unsigned SDRAM_AW = 29;
    localparam int unsigned SDRAM_DW = 64;

    // Lane i lives at bit offset 16*i: {0, 16, 32, 48}
    function automatic int unsigned lane_off(input int unsigned idx);
        return idx * 16;
    endfunction

endpackage

// File: rtl/dma_to_sdram_if.sv
// Pixel-buffer read port and Avalon-MM write port bundled for the capture DMA.
interface dma_to_sdram_if #(
    parameter int unsigned BUF_AW = 10,
    parameter int unsigned PIX_W  = 12
);
    logic [BUF_AW-1:0] buf_address;
    logic              buf_rd_en;
    logic [PIX_W-1:0]  buf_data;

    logic [28:0]       sdram0_data_address;
    logic              sdram0_data_write;
    logic [63:0]       sdram0_data_writedata;
    logic [7:0]        sdram0_data_byteenable;
    logic [7:0]        sdram0_data_burstcount;
    logic              sdram0_data_waitrequest;

    modport master (
        output buf_address, buf_rd_en,
        input  buf_data,
        output sdram0_data_address, sdram0_data_write, sdram0_data_writedata,
        output sdram0_data_byteenable, sdram0_data_burstcount,
        input  sdram0_data_waitrequest
    );

    modport slave (
        input  buf_address, buf_rd_en,
        output buf_data,
        input  sdram0_data_address, sdram0_data_write, sdram0_data_writedata,
        input  sdram0_data_byteenable, sdram0_data_burstcount,
        output sdram0_data_waitrequest
    );
endinterface

// File: rtl/pixel_pack4.sv
// Collects four pixels into one 64-bit SDRAM word (lane i at bits [16*i +: PixW]).
module pixel_pack4 #(
    parameter int unsigned PixW = 12
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            cap_i,
    input  logic [1:0]      lane_i,
    input  logic [PixW-1:0] pix_i,
    output logic [63:0]     word_o
);
    import matrix_dma_pkg::*;

    logic [LANES-1:0][PixW-1:0] lane_q;

    // Lane registers: clear on request, otherwise overwrite the addressed lane
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
        end else if (cap_i) begin
            lane_q[lane_i] <= pix_i;
        end
    end

    // Spread lanes into the word; gap nibbles stay zero
    always_comb begin
        word_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            word_o[lane_off(i) +: PixW] = lane_q[i];
        end
    end

endmodule

// File: rtl/dma_to_sdram.sv
// Frame-capture DMA: reads pixels from the pixel buffer, packs four per word and writes them
// to HPS SDRAM over Avalon-MM. Optional macro DMA_TO_SDRAM_ABORT_EN adds an `abort` input.
module dma_to_sdram #(
    parameter int unsigned BUF_AW = 10,
    parameter int unsigned PIX_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [28:0]           begin_address,
    input  logic [31:0]           size_buffer,
`ifdef DMA_TO_SDRAM_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    dma_to_sdram_if.master        bus
);
    import matrix_dma_pkg::*;

    dma_state_e          state_q, state_d;
    logic [2:0]          phase_q, phase_d;
    logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
    logic [SDRAM_AW-1:0] sd_addr_q, sd_addr_d;
    logic [31:0]         count_q, count_d;
    logic [2:0]          phase_m1;
    logic                pack_clr, pack_cap;
    logic [SDRAM_DW-1:0] pack_word;
`ifdef DMA_TO_SDRAM_ABORT_EN
    logic                abort_pend_q, abort_pend_d;
`endif

    assign phase_m1 = phase_q - 3'd1;

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

    assign bus.buf_address            = buf_addr_q;
    assign bus.sdram0_data_address    = sd_addr_q;
    assign bus.sdram0_data_writedata  = pack_word;
    assign bus.sdram0_data_byteenable = 8'hFF;
    assign bus.sdram0_data_burstcount = 8'd1;

    pixel_pack4 #(
        .PixW (PIX_W)
    ) u_pack (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (pack_clr),
        .cap_i  (pack_cap),
        .lane_i (phase_m1[1:0]),
        .pix_i  (bus.buf_data),
        .word_o (pack_word)
    );

    // State, counters and addresses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            buf_addr_q <= '0;
            sd_addr_q  <= '0;
            count_q    <= '0;
`ifdef DMA_TO_SDRAM_ABORT_EN
            abort_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            buf_addr_q <= buf_addr_d;
            sd_addr_q  <= sd_addr_d;
            count_q    <= count_d;
`ifdef DMA_TO_SDRAM_ABORT_EN
            abort_pend_q <= abort_pend_d;
`endif
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d                = state_q;
        phase_d                = phase_q;
        buf_addr_d             = buf_addr_q;
        sd_addr_d              = sd_addr_q;
        count_d                = count_q;
        pack_clr               = 1'b0;
        pack_cap               = 1'b0;
        bus.buf_rd_en          = 1'b0;
        bus.sdram0_data_write  = 1'b0;
`ifdef DMA_TO_SDRAM_ABORT_EN
        abort_pend_d           = abort_pend_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sd_addr_d  = begin_address;
                    count_d    = '0;
                    buf_addr_d = '0;
                    phase_d    = '0;
                    pack_clr   = 1'b1;
`ifdef DMA_TO_SDRAM_ABORT_EN
                    abort_pend_d = 1'b0;
`endif
                    state_d    = (size_buffer == 32'd0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                // Reads issue in phases 0..3; data lands one phase later into lane phase-1
                if (phase_q != 3'd4) begin
                    bus.buf_rd_en = 1'b1;
                    buf_addr_d    = buf_addr_q + 1'b1;
                end
                if (phase_q != 3'd0) begin
                    pack_cap = 1'b1;
                end
                if (phase_q == 3'd4) begin
                    phase_d = '0;
                    state_d = StWrite;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
`ifdef DMA_TO_SDRAM_ABORT_EN
                if (abort) begin
                    phase_d = '0;
                    state_d = StDone;
                end
`endif
            end
            StWrite: begin
                bus.sdram0_data_write = 1'b1;
`ifdef DMA_TO_SDRAM_ABORT_EN
                // Abort is remembered so the pending Avalon write still completes
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
`endif
                if (!bus.sdram0_data_waitrequest) begin
                    count_d   = count_q + 32'd1;
                    sd_addr_d = sd_addr_q + 1'b1;
                    if (count_d == size_buffer) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                    end
`ifdef DMA_TO_SDRAM_ABORT_EN
                    if (abort || abort_pend_q) begin
                        state_d = StDone;
                    end
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_to_sdram.sv
// Scoreboard bench for dma_to_sdram: expected Avalon writes are queued by the stimulus and
// popped by a monitor on every accepted write. Define DMA_TO_SDRAM_ABORT_EN for the abort case.
module tb_dma_to_sdram;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [28:0] begin_address = '0;
    logic [31:0] size_buffer = '0;
    logic        busy, done;
    logic        waitreq = 1'b0;
`ifdef DMA_TO_SDRAM_ABORT_EN
    logic        abort_in = 1'b0;
    int          abort_word = -1;
`endif

    logic [11:0] mem [1024];
    wr_t         exp_q [$];

    int n_checks = 0;
    int n_fail = 0;
    int n_reads = 0;
    int n_writes = 0;
    int stall_left = 0;
    int stall_from = 0;

    logic        held_valid = 1'b0;
    logic [28:0] held_addr;
    logic [63:0] held_data;
    logic        accept_prev = 1'b0;

    dma_to_sdram_if #(.BUF_AW(10), .PIX_W(12)) bus ();

    dma_to_sdram #(
        .BUF_AW (10),
        .PIX_W  (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .begin_address (begin_address),
        .size_buffer   (size_buffer),
`ifdef DMA_TO_SDRAM_ABORT_EN
        .abort         (abort_in),
`endif
        .busy          (busy),
        .done          (done),
        .bus           (bus.master)
    );

    assign bus.sdram0_data_waitrequest = waitreq;

    always #5 clk = ~clk;

    // Synchronous buffer model: data one cycle after the read enable
    always @(posedge clk) begin
        if (bus.buf_rd_en) bus.buf_data <= mem[bus.buf_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int base);
        return {4'h0, mem[(base + 3) % 1024], 4'h0, mem[(base + 2) % 1024],
                4'h0, mem[(base + 1) % 1024], 4'h0, mem[base % 1024]};
    endfunction

    // Drives waitrequest for the coming edge, then checks what the DUT presents
    always @(negedge clk) begin
        if (!rst) begin
            waitreq     = 1'b0;
            held_valid  = 1'b0;
            accept_prev = 1'b0;
        end else begin
            if (bus.sdram0_data_write && stall_left > 0 && n_writes >= stall_from) begin
                waitreq = 1'b1;
                stall_left--;
            end else begin
                waitreq = 1'b0;
            end
`ifdef DMA_TO_SDRAM_ABORT_EN
            abort_in = bus.sdram0_data_write && waitreq && (n_writes == abort_word);
`endif
            if (bus.buf_rd_en) n_reads++;
            if (held_valid) begin
                check("stall_addr_stable", 64'(bus.sdram0_data_address), 64'(held_addr));
                check("stall_data_stable", bus.sdram0_data_writedata, held_data);
            end
            held_valid = bus.sdram0_data_write && waitreq;
            held_addr  = bus.sdram0_data_address;
            held_data  = bus.sdram0_data_writedata;
            if (bus.sdram0_data_write && !waitreq) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.sdram0_data_address, bus.sdram0_data_writedata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.sdram0_data_address), 64'(e.addr));
                    check("wr_data", bus.sdram0_data_writedata, e.data);
                end
                check("byteenable", 64'(bus.sdram0_data_byteenable), 64'hFF);
                check("burstcount", 64'(bus.sdram0_data_burstcount), 64'd1);
            end
            if (done && n_writes > 0) check("done_after_accept", 64'(accept_prev), 64'd1);
            accept_prev = bus.sdram0_data_write && !waitreq;
        end
    end

    // Issues one start and counts negedges until done (bounded)
    task automatic run(input logic [28:0] a, input logic [31:0] sz, input int limit,
                       output int cyc);
        @(negedge clk);
        n_reads       = 0;
        n_writes      = 0;
        start         = 1'b1;
        begin_address = a;
        size_buffer   = sz;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) mem[i] = 12'(i * 7 + 3);
        mem[0] = 12'h111; mem[1] = 12'h222; mem[2] = 12'h333; mem[3] = 12'h444;

        // Reset values
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(bus.buf_rd_en), 64'd0);
        check("rst_write", 64'(bus.sdram0_data_write), 64'd0);
        check("rst_buf_addr", 64'(bus.buf_address), 64'd0);
        check("rst_sd_addr", 64'(bus.sdram0_data_address), 64'd0);
        check("rst_wdata", bus.sdram0_data_writedata, 64'd0);
        rst = 1'b1;

        // Single word, no stalls: write at cycle 6, done at cycle 7
        exp_q.push_back('{addr: 29'h100, data: 64'h0444_0333_0222_0111});
        run(29'h100, 32'd1, 50, cyc);
        check("single_latency", 64'(cyc), 64'd7);
        check("single_writes", 64'(n_writes), 64'd1);
        check("single_reads", 64'(n_reads), 64'd4);
        check("single_queue_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: five stall cycles, write held six cycles
        stall_from = 0;
        stall_left = 5;
        exp_q.push_back('{addr: 29'h100, data: 64'h0444_0333_0222_0111});
        run(29'h100, 32'd1, 50, cyc);
        check("bp_latency", 64'(cyc), 64'd12);
        check("bp_writes", 64'(n_writes), 64'd1);

        // Zero size: immediate done, no traffic
        run(29'h55, 32'd0, 20, cyc);
        check("zero_done_by_cycle2", 64'(cyc <= 2), 64'd1);
        check("zero_reads", 64'(n_reads), 64'd0);
        check("zero_writes", 64'(n_writes), 64'd0);

        // Reset while a write is stalled
        stall_left = 1000;
        @(negedge clk);
        start         = 1'b1;
        begin_address = 29'h200;
        size_buffer   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !bus.sdram0_data_write; i++) @(negedge clk);
        check("rstmid_write_seen", 64'(bus.sdram0_data_write), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rstmid_write_drop", 64'(bus.sdram0_data_write), 64'd0);
        check("rstmid_idle", 64'(busy), 64'd0);
        stall_left = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back('{addr: 29'h100, data: 64'h0444_0333_0222_0111});
        run(29'h100, 32'd1, 50, cyc);
        check("rstmid_restart_latency", 64'(cyc), 64'd7);
        check("rstmid_restart_writes", 64'(n_writes), 64'd1);

        // Multi-word with buffer and SDRAM address wrap
        for (int i = 0; i < 4; i++) mem[i] = 12'(i * 7 + 3);
        for (int w = 0; w < 257; w++) begin
            if (w == 256)
                exp_q.push_back('{addr: 29'h000_0080, data: 64'h0018_0011_000A_0003});
            else
                exp_q.push_back('{addr: 29'(29'h1FFF_FF80 + w), data: pack(4 * w)});
        end
        run(29'h1FFF_FF80, 32'd257, 3000, cyc);
        check("multi_latency", 64'(cyc), 64'd1543);
        check("multi_writes", 64'(n_writes), 64'd257);
        check("multi_reads", 64'(n_reads), 64'd1028);
        check("multi_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef DMA_TO_SDRAM_ABORT_EN
        // Abort during a stalled write of word 3: it completes, no word 4 fetch
        stall_from = 3;
        stall_left = 3;
        abort_word = 3;
        for (int w = 0; w < 4; w++) exp_q.push_back('{addr: 29'(w), data: pack(4 * w)});
        run(29'h0, 32'd8, 200, cyc);
        abort_word = -1;
        check("abort_writes", 64'(n_writes), 64'd4);
        check("abort_reads", 64'(n_reads), 64'd16);
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
